// File: rtl/lockstep_trojan_monitor.sv
// Compares suspect vs golden result streams per channel with per-channel golden queues; counters, flags and state update 1 cycle after sampling.
// No backpressure: a golden word arriving at a full queue is dropped and flagged, and a suspect word with nothing to compare is flagged.
module lockstep_trojan_monitor #(
  parameter int DATA_W     = 128,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int THRESH     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        g_valid,
  input  logic [NUM_CH*DATA_W-1:0] g_data,
  input  logic [NUM_CH-1:0]        s_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic [CNT_W-1:0]         test_count,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic [NUM_CH-1:0]        mismatch_ch,
  output logic [DATA_W-1:0]        last_diff,
  output logic                     alarm,
  output logic                     protocol_err,
  output logic [1:0]               state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);
  localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]      FULL_V   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MONITOR = 2'b01,
    ALARM   = 2'b10
  } state_t;

  state_t cur_state, nxt_state;

  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW:0]       fill   [NUM_CH];
  logic [DATA_W-1:0] diff   [NUM_CH];

  logic              active;
  logic [NUM_CH-1:0] empty, full, do_cmp, mis, push, pop, err;
  logic [SUM_W-1:0]  test_sum, mis_sum;
  logic [DATA_W-1:0] first_diff;

  // Per-channel compare/queue decisions; walking channels high-to-low leaves the lowest mismatch in first_diff.
  always_comb begin
    active     = (cur_state != IDLE) && enable;
    empty      = '0;
    full       = '0;
    do_cmp     = '0;
    mis        = '0;
    push       = '0;
    pop        = '0;
    err        = '0;
    test_sum   = {{(SUM_W-CNT_W){1'b0}}, test_count};
    mis_sum    = {{(SUM_W-CNT_W){1'b0}}, mismatch_count};
    first_diff = last_diff;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      empty[c]  = (fill[c] == '0);
      full[c]   = (fill[c] == FULL_V);
      diff[c]   = (empty[c] ? g_data[c*DATA_W +: DATA_W] : mem[c][rd_ptr[c]])
                  ^ s_data[c*DATA_W +: DATA_W];
      do_cmp[c] = active && s_valid[c] && (!empty[c] || g_valid[c]);
      pop[c]    = do_cmp[c] && !empty[c];
      push[c]   = active && g_valid[c] && !(do_cmp[c] && empty[c]) && (!full[c] || pop[c]);
      err[c]    = active && ((s_valid[c] && empty[c] && !g_valid[c]) ||
                             (g_valid[c] && full[c] && !pop[c]));
      mis[c]    = do_cmp[c] && (diff[c] != '0);
      test_sum  = test_sum + SUM_W'(do_cmp[c]);
      mis_sum   = mis_sum + SUM_W'(mis[c]);
      if (mis[c]) first_diff = diff[c];
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (enable) nxt_state = MONITOR;
      MONITOR: begin
        if (!enable)                  nxt_state = IDLE;
        else if (mis_sum >= THRESH_V) nxt_state = ALARM;
      end
      ALARM:   nxt_state = ALARM;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) cur_state <= IDLE;
    else               cur_state <= nxt_state;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= g_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      test_count     <= '0;
      mismatch_count <= '0;
      mismatch_ch    <= '0;
      last_diff      <= '0;
      protocol_err   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        fill[c]   <= '0;
      end
    end else begin
      test_count     <= (test_sum[SUM_W-1:CNT_W] != '0) ? CNT_MAX : test_sum[CNT_W-1:0];
      mismatch_count <= (mis_sum[SUM_W-1:CNT_W] != '0) ? CNT_MAX : mis_sum[CNT_W-1:0];
      mismatch_ch    <= mismatch_ch | mis;
      if (|mis) last_diff <= first_diff;
      if (|err) protocol_err <= 1'b1;
      // Leaving the active states silently discards whatever golden words are queued.
      for (int c = 0; c < NUM_CH; c++) begin
        if (!active) begin
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
          fill[c]   <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
          case ({push[c], pop[c]})
            2'b10:   fill[c] <= fill[c] + (AW+1)'(1);
            2'b01:   fill[c] <= fill[c] - (AW+1)'(1);
            default: fill[c] <= fill[c];
          endcase
        end
      end
    end
  end

  assign alarm = (cur_state == ALARM);
  assign state = cur_state;

endmodule

// File: tb/tb_lockstep_trojan_monitor.sv
// Bench: two monitor instances (default and CNT_W=4/THRESH=8) driven by shared directed and random
// stimulus, checked every cycle against a queue-based reference model plus directed scenario checks.
module tb_lockstep_trojan_monitor;

  logic         clk = 1'b0;
  logic         rst, enable, clear;
  logic [1:0]   gv, sv;
  logic [255:0] gd, sd;

  logic [15:0]  tc_a, mc_a;
  logic [3:0]   tc_b, mc_b;
  logic [1:0]   mch_a, mch_b, st_a, st_b;
  logic [127:0] ld_a, ld_b;
  logic         alarm_a, alarm_b, pe_a, pe_b;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  lockstep_trojan_monitor u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .g_valid(gv), .g_data(gd), .s_valid(sv), .s_data(sd),
    .test_count(tc_a), .mismatch_count(mc_a), .mismatch_ch(mch_a), .last_diff(ld_a),
    .alarm(alarm_a), .protocol_err(pe_a), .state(st_a)
  );

  lockstep_trojan_monitor #(.CNT_W(4), .THRESH(8)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .g_valid(gv), .g_data(gd), .s_valid(sv), .s_data(sd),
    .test_count(tc_b), .mismatch_count(mc_b), .mismatch_ch(mch_b), .last_diff(ld_b),
    .alarm(alarm_b), .protocol_err(pe_b), .state(st_b)
  );

  // Reference model: golden queues per (instance, channel), plain integer counters.
  logic [127:0] mq [4][$];
  int           m_tc [2];
  int           m_mc [2];
  int           m_st [2];
  logic [1:0]   m_mch [2];
  logic [127:0] m_ld [2];
  logic         m_pe [2];

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void model_step(input int m, input int cmax, input int thresh);
    int ncmp, nmis;
    logic [127:0] g, s, r, d;
    logic found, have;
    if (!rst || clear) begin
      m_tc[m] = 0; m_mc[m] = 0; m_st[m] = 0;
      m_mch[m] = '0; m_ld[m] = '0; m_pe[m] = 1'b0;
      for (int c = 0; c < 2; c++) mq[m*2+c].delete();
    end else if (m_st[m] == 0 || !enable) begin
      for (int c = 0; c < 2; c++) mq[m*2+c].delete();
      if (m_st[m] == 0 && enable)      m_st[m] = 1;
      else if (m_st[m] == 1 && !enable) m_st[m] = 0;
    end else begin
      ncmp = 0; nmis = 0; found = 1'b0;
      for (int c = 0; c < 2; c++) begin
        g = gd[c*128 +: 128];
        s = sd[c*128 +: 128];
        have = 1'b0;
        r = '0;
        if (sv[c]) begin
          if (mq[m*2+c].size() > 0) begin
            r = mq[m*2+c].pop_front();
            have = 1'b1;
            if (gv[c]) mq[m*2+c].push_back(g);
          end else if (gv[c]) begin
            r = g;
            have = 1'b1;
          end else begin
            m_pe[m] = 1'b1;
          end
          if (have) begin
            ncmp++;
            d = r ^ s;
            if (d != '0) begin
              nmis++;
              m_mch[m][c] = 1'b1;
              if (!found) begin
                m_ld[m] = d;
                found = 1'b1;
              end
            end
          end
        end else if (gv[c]) begin
          if (mq[m*2+c].size() >= 4) m_pe[m] = 1'b1;
          else                       mq[m*2+c].push_back(g);
        end
      end
      m_tc[m] = (m_tc[m] + ncmp > cmax) ? cmax : m_tc[m] + ncmp;
      if (m_st[m] == 1 && m_mc[m] + nmis >= thresh) m_st[m] = 2;
      m_mc[m] = (m_mc[m] + nmis > cmax) ? cmax : m_mc[m] + nmis;
    end
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tc_a", 128'(tc_a), 128'(m_tc[0]));
    chk("mc_a", 128'(mc_a), 128'(m_mc[0]));
    chk("mch_a", 128'(mch_a), 128'(m_mch[0]));
    chk("ld_a", ld_a, m_ld[0]);
    chk("pe_a", 128'(pe_a), 128'(m_pe[0]));
    chk("st_a", 128'(st_a), 128'(m_st[0]));
    chk("alarm_a", 128'(alarm_a), 128'(m_st[0] == 2));
    chk("tc_b", 128'(tc_b), 128'(m_tc[1]));
    chk("mc_b", 128'(mc_b), 128'(m_mc[1]));
    chk("mch_b", 128'(mch_b), 128'(m_mch[1]));
    chk("ld_b", ld_b, m_ld[1]);
    chk("pe_b", 128'(pe_b), 128'(m_pe[1]));
    chk("st_b", 128'(st_b), 128'(m_st[1]));
    chk("alarm_b", 128'(alarm_b), 128'(m_st[1] == 2));
  endtask

  task automatic cycle();
    model_step(0, 65535, 1);
    model_step(1, 15, 8);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    gv = '0; sv = '0; gd = '0; sd = '0;
  endtask

  // Clear then one enabled cycle so both instances sit in MONITOR with empty queues.
  task automatic restart();
    quiet();
    clear = 1'b1; enable = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();
  endtask

  logic [127:0] v0 [100];
  logic [127:0] v1 [100];
  logic [127:0] pool [3];

  initial begin
    rst = 1'b0; enable = 1'b0; clear = 1'b0;
    quiet();

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      enable = 1'($urandom()); clear = 1'($urandom());
      gv = 2'($urandom()); sv = 2'($urandom());
      gd = {rand128(), rand128()}; sd = {rand128(), rand128()};
      cycle();
    end
    chk("rst_state", 128'(st_a), 128'(0));
    chk("rst_tc", 128'(tc_a), 128'(0));
    chk("rst_ld", ld_a, 128'(0));
    chk("rst_flags", 128'({alarm_a, pe_a, mch_a}), 128'(0));

    // Matching stream, suspect two cycles behind golden.
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    quiet();
    cycle();
    for (int i = 0; i < 100; i++) begin
      v0[i] = rand128();
      v1[i] = rand128();
    end
    for (int t = 0; t < 102; t++) begin
      quiet();
      if (t < 100) begin
        gv = 2'b11;
        gd = {v1[t], v0[t]};
      end
      if (t >= 2) begin
        sv = 2'b11;
        sd = {v1[t-2], v0[t-2]};
      end
      cycle();
    end
    chk("skew_tc", 128'(tc_a), 128'(200));
    chk("skew_mc", 128'(mc_a), 128'(0));
    chk("skew_alarm", 128'(alarm_a), 128'(0));
    chk("skew_pe", 128'(pe_a), 128'(0));

    // Single bit flip on channel 1 suspect word 10.
    restart();
    for (int i = 0; i < 20; i++) begin
      v0[i] = rand128();
      v1[i] = rand128();
    end
    for (int t = 0; t < 22; t++) begin
      quiet();
      if (t < 20) begin
        gv = 2'b11;
        gd = {v1[t], v0[t]};
      end
      if (t >= 2) begin
        sv = 2'b11;
        sd = {((t == 12) ? (v1[t-2] ^ 128'h1) : v1[t-2]), v0[t-2]};
      end
      cycle();
      if (t == 11) chk("flip_pre_alarm", 128'(alarm_a), 128'(0));
      if (t == 12) begin
        chk("flip_mc", 128'(mc_a), 128'(1));
        chk("flip_mch", 128'(mch_a), 128'(2'b10));
        chk("flip_ld", ld_a, 128'h1);
        chk("flip_alarm", 128'(alarm_a), 128'(1));
        chk("flip_state", 128'(st_a), 128'(2'b10));
      end
    end

    // Overflow of the channel 0 queue, then an orphan suspect word.
    restart();
    for (int i = 0; i < 5; i++) begin
      quiet();
      v0[i] = rand128();
      gv = 2'b01;
      gd = {128'h0, v0[i]};
      cycle();
    end
    chk("ovf_pe", 128'(pe_a), 128'(1));
    for (int i = 0; i < 4; i++) begin
      quiet();
      sv = 2'b01;
      sd = {128'h0, v0[i]};
      cycle();
    end
    chk("ovf_tc", 128'(tc_a), 128'(4));
    chk("ovf_mc", 128'(mc_a), 128'(0));
    quiet();
    sv = 2'b01;
    sd = {128'h0, v0[4]};
    cycle();
    chk("orphan_tc", 128'(tc_a), 128'(4));

    // Saturation on the narrow-counter instance.
    restart();
    for (int i = 0; i < 20; i++) begin
      quiet();
      gv = 2'b11;
      sv = 2'b01;
      v0[i] = rand128();
      gd = {rand128(), v0[i]};
      sd = {128'h0, v0[i] ^ (rand128() | 128'h1)};
      cycle();
      if (i == 6) chk("sat_pre_alarm", 128'(alarm_b), 128'(0));
    end
    chk("sat_mc", 128'(mc_b), 128'(15));
    chk("sat_alarm", 128'(alarm_b), 128'(1));
    chk("sat_state", 128'(st_b), 128'(2'b10));

    // Clear coinciding with a mismatch, then reset with half-full queues.
    restart();
    gv = 2'b01; sv = 2'b01;
    gd = {128'h0, rand128()};
    sd = {128'h0, ~gd[127:0]};
    cycle();
    chk("pre_clear_alarm", 128'(alarm_a), 128'(1));
    clear = 1'b1;
    gd = {128'h0, rand128()};
    sd = {128'h0, ~gd[127:0]};
    cycle();
    chk("clr_tc", 128'(tc_a), 128'(0));
    chk("clr_mc", 128'(mc_a), 128'(0));
    chk("clr_alarm", 128'(alarm_a), 128'(0));
    chk("clr_state", 128'(st_a), 128'(0));
    clear = 1'b0;
    quiet();
    cycle();
    for (int i = 0; i < 2; i++) begin
      gv = 2'b11;
      gd = {rand128(), rand128()};
      cycle();
    end
    quiet();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    gv = 2'b01; sv = 2'b01;
    gd = {128'h0, rand128()};
    sd = gd;
    cycle();
    chk("rst_mid_tc", 128'(tc_a), 128'(1));
    chk("rst_mid_mc", 128'(mc_a), 128'(0));

    // Random traffic from a small data pool so matches and mismatches both occur.
    for (int i = 0; i < 3; i++) pool[i] = rand128();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(199) != 0);
      clear  = ($urandom_range(59) == 0);
      enable = ($urandom_range(39) != 0);
      gv = 2'($urandom());
      sv = 2'($urandom());
      gd = {pool[$urandom_range(2)], pool[$urandom_range(2)]};
      sd = {pool[$urandom_range(2)], pool[$urandom_range(2)]};
      cycle();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
